mem_bus_arbiter: RTL and testbench

Two-master arbiter for the SoC's native valid/ready memory bus. It shares the single slave-side bus (address decoder, flash, SRAM, LEDs, systick, UART) between the CPU (master 0) and a second bus master such as a DMA or debug loader (master 1). Grants are round-robin, with optional fixed priority. A bus watchdog completes any transaction that no slave acknowledges, so an unmapped access cannot hang a master.

---
 rtl/mem_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one slave-side valid/ready memory bus between two
// masters (m0 = CPU, m1 = DMA / debug loader). Round-robin or fixed-priority
// grant, plus a watchdog that force-completes transactions nobody acknowledges.
//
// Handshake (all ports): a master raises mX_valid with addr/wdata/wstrb stable
// and holds them until mX_ready pulses for one cycle; the transfer completes
// in that cycle and mX_rdata is meaningful only while mX_ready=1. The slave
// side works the same way: s_valid/s_addr/... are held until s_ready=1, which
// completes the forwarded transfer in the same cycle.
module mem_bus_arbiter #(
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  // master 0
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  // master 1
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  // slave side
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  // watchdog reporting
  output logic        timeout_irq,
  output logic [31:0] err_addr,
  output logic        err_master,
  // debug: current FSM state (0 = IDLE, 1 = BUSY)
  output logic        dbg_state
);

  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  // Count value reached in the last BUSY cycle before the watchdog fires.
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   err_addr_q, err_addr_d;
  logic          err_master_q, err_master_d;

  // Request fields of whichever master currently owns the bus.
  logic          gnt_valid;
  logic [31:0]   gnt_addr;
  logic [31:0]   gnt_wdata;
  logic [3:0]    gnt_wstrb;
  logic          tmo_hit;
  logic [31:0]   done_rdata;

  // State register and datapath registers; reset drops any in-flight transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;   // so master 0 wins the first contention
      tcnt_q       <= '0;
      err_addr_q   <= '0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tcnt_q       <= tcnt_d;
      err_addr_q   <= err_addr_d;
      err_master_q <= err_master_d;
    end
  end

  // Select the granted master's request and flag the final watchdog cycle.
  always_comb begin
    gnt_valid = m0_valid;
    gnt_addr  = m0_addr;
    gnt_wdata = m0_wdata;
    gnt_wstrb = m0_wstrb;
    if (grant_q) begin
      gnt_valid = m1_valid;
      gnt_addr  = m1_addr;
      gnt_wdata = m1_wdata;
      gnt_wstrb = m1_wstrb;
    end
    tmo_hit = (tcnt_q == TCNT_LAST);
  end

  // Next-state logic: arbitration in IDLE, completion/timeout/abort in BUSY.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tcnt_d       = tcnt_q;
    err_addr_d   = err_addr_q;
    err_master_d = err_master_q;
    case (state_q)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = S_BUSY;
          tcnt_d  = '0;
          if (m0_valid && m1_valid) begin
            grant_d = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
          end else begin
            // exactly one requester: m1_valid is its index
            grant_d = m1_valid;
          end
        end
      end
      S_BUSY: begin
        if (!gnt_valid) begin
          // Master withdrew its request: abandon quietly, fairness untouched.
          state_d = S_IDLE;
        end else if (s_ready) begin
          // A real acknowledge beats the watchdog in the same cycle.
          state_d      = S_IDLE;
          last_grant_d = grant_q;
        end else if (tmo_hit) begin
          state_d      = S_IDLE;
          last_grant_d = grant_q;
          err_addr_d   = gnt_addr;
          err_master_d = grant_q;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: slave-side forwarding and master completion in BUSY only.
  always_comb begin
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    timeout_irq = 1'b0;
    done_rdata  = '0;
    if (state_q == S_BUSY) begin
      s_valid = gnt_valid;
      s_addr  = gnt_addr;
      s_wdata = gnt_wdata;
      s_wstrb = gnt_wstrb;
      if (gnt_valid && (s_ready || tmo_hit)) begin
        // Forced completions return ERR_RDATA even for writes.
        done_rdata  = s_ready ? s_rdata : ERR_RDATA;
        timeout_irq = ~s_ready;
        if (grant_q) begin
          m1_ready = 1'b1;
          m1_rdata = done_rdata;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = done_rdata;
        end
      end
    end
  end

  assign err_addr   = err_addr_q;
  assign err_master = err_master_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int          T       = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus ----------------
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  // round-robin instance outputs
  logic        rr_m0_ready, rr_m1_ready, rr_s_valid, rr_irq, rr_err_master, rr_state;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata, rr_err_addr;
  logic [3:0]  rr_s_wstrb;
  // fixed-priority instance outputs
  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_irq, fp_err_master, fp_state;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata, fp_err_addr;
  logic [3:0]  fp_s_wstrb;

  mem_bus_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(T), .ERR_RDATA(ERR_VAL)) u_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
    .s_valid(rr_s_valid), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_irq(rr_irq), .err_addr(rr_err_addr), .err_master(rr_err_master),
    .dbg_state(rr_state)
  );

  mem_bus_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(T), .ERR_RDATA(ERR_VAL)) u_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_irq(fp_irq), .err_addr(fp_err_addr), .err_master(fp_err_master),
    .dbg_state(fp_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];   // {master, rdata} of completions the model predicts

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (rr instance) ----------------
  int          mdl_busy, mdl_owner, mdl_waited, mdl_last;
  logic [31:0] mdl_err_addr;
  logic        mdl_err_master;
  logic        e_sv, e_irq, e_err_master;
  logic [31:0] e_saddr, e_swdata, e_err_addr;
  logic [3:0]  e_swstrb;
  logic        e_ready[2];
  logic [31:0] e_rdata[2];

  task automatic model_init();
    mdl_busy = 0; mdl_owner = 0; mdl_waited = 0; mdl_last = 1;
    mdl_err_addr = '0; mdl_err_master = 1'b0;
    e_ready[0] = 1'b0; e_ready[1] = 1'b0;
  endtask

  // One bus cycle: predict the visible outputs from the current inputs, then
  // advance the transaction bookkeeping to the next cycle.
  task automatic model_step();
    logic        v[2];
    logic [31:0] a[2], wd[2];
    logic [3:0]  ws[2];
    int          o;
    v[0] = m0_valid; a[0] = m0_addr; wd[0] = m0_wdata; ws[0] = m0_wstrb;
    v[1] = m1_valid; a[1] = m1_addr; wd[1] = m1_wdata; ws[1] = m1_wstrb;
    e_sv = 1'b0; e_irq = 1'b0; e_saddr = '0; e_swdata = '0; e_swstrb = '0;
    e_ready[0] = 1'b0; e_ready[1] = 1'b0; e_rdata[0] = '0; e_rdata[1] = '0;
    e_err_addr = mdl_err_addr; e_err_master = mdl_err_master;
    if (mdl_busy == 0) begin
      if (v[0] || v[1]) begin
        mdl_busy = 1;
        mdl_waited = 0;
        if (v[0] && v[1]) mdl_owner = 1 - mdl_last;
        else mdl_owner = v[1] ? 1 : 0;
      end
    end else begin
      o = mdl_owner;
      e_saddr = a[o]; e_swdata = wd[o]; e_swstrb = ws[o];
      if (!v[o]) begin
        mdl_busy = 0;
      end else begin
        e_sv = 1'b1;
        mdl_waited++;   // bus cycles spent on this request, this one included
        if (s_ready) begin
          e_ready[o] = 1'b1; e_rdata[o] = s_rdata;
          mdl_last = o; mdl_busy = 0;
        end else if (mdl_waited == T) begin
          e_ready[o] = 1'b1; e_rdata[o] = ERR_VAL; e_irq = 1'b1;
          mdl_err_addr = a[o]; mdl_err_master = (o == 1);
          mdl_last = o; mdl_busy = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    m0_valid = 0; m1_valid = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_wstrb = '0; m1_wstrb = '0;
    s_ready = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic v0, v1;
    logic [31:0] a0, a1, wd0, wd1;
    logic [3:0] ws0, ws1;
    logic sr;
    logic [31:0] srd;
    logic e_sv;
    logic [31:0] e_saddr, e_swdata;
    logic [3:0] e_swstrb;
    logic e_r0, e_r1;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] wd1, input logic [3:0] ws1, input logic sr,
                         input logic [31:0] srd, input int owner);
    vec_t r;
    r.v0 = v0; r.v1 = v1; r.a0 = a0; r.a1 = a1; r.wd0 = '0; r.wd1 = wd1;
    r.ws0 = '0; r.ws1 = ws1; r.sr = sr; r.srd = srd;
    r.e_sv = 1'b0; r.e_saddr = '0; r.e_swdata = '0; r.e_swstrb = '0;
    r.e_r0 = 1'b0; r.e_r1 = 1'b0; r.e_rd0 = '0; r.e_rd1 = '0;
    // owner: -1 = arbiter idle, 0/1 = that master on the bus, +10 = on bus but not completing
    if (owner == 0 || owner == 1 || owner == 10 || owner == 11) begin
      r.e_sv = 1'b1;
      r.e_saddr  = (owner % 10 == 1) ? a1 : a0;
      r.e_swdata = (owner % 10 == 1) ? wd1 : '0;
      r.e_swstrb = (owner % 10 == 1) ? ws1 : '0;
      if (owner == 0) begin r.e_r0 = 1'b1; r.e_rd0 = srd; end
      if (owner == 1) begin r.e_r1 = 1'b1; r.e_rd1 = srd; end
    end
    vecs.push_back(r);
  endtask

  task automatic build_table();
    // contention, zero-wait slave: idle gap then grant, alternating 0,1,0,1...
    for (int i = 0; i < 16; i++) begin
      add_vec(1, 1, 32'h0000_0100, 32'h0000_0200, 32'h55AA_0000, 4'hF, 1, 32'h1000 + i,
              (i % 2 == 0) ? -1 : ((i / 2) % 2));
    end
    // single read by m0
    add_vec(1, 0, 32'h0002_0004, 32'h0, 32'h0, 4'h0, 1, 32'h1234_5678, -1);
    add_vec(1, 0, 32'h0002_0004, 32'h0, 32'h0, 4'h0, 1, 32'h1234_5678, 0);
    add_vec(0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 32'h0, -1);
    // m1 read with one wait state
    add_vec(0, 1, 32'h0, 32'h0000_0300, 32'h0, 4'h0, 0, 32'hBEEF_0002, -1);
    add_vec(0, 1, 32'h0, 32'h0000_0300, 32'h0, 4'h0, 0, 32'hBEEF_0002, 11);
    add_vec(0, 1, 32'h0, 32'h0000_0300, 32'h0, 4'h0, 1, 32'hBEEF_0002, 1);
    add_vec(0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 32'h0, -1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- main test ----------------
  initial begin
    int irq_seen;
    logic        mv[2];
    logic [31:0] ma[2], mw[2];
    logic [3:0]  ms[2];
    logic [32:0] got, want;

    reset = 1'b1;
    idle_inputs();
    #1;
    check("reset_s_valid", rr_s_valid, 0);
    check("reset_err_addr", rr_err_addr, 0);
    check("reset_state", rr_state, 0);
    do_reset();

    // ---- table-driven vectors ----
    build_table();
    foreach (vecs[k]) begin
      m0_valid = vecs[k].v0; m1_valid = vecs[k].v1;
      m0_addr = vecs[k].a0; m1_addr = vecs[k].a1;
      m0_wdata = vecs[k].wd0; m1_wdata = vecs[k].wd1;
      m0_wstrb = vecs[k].ws0; m1_wstrb = vecs[k].ws1;
      s_ready = vecs[k].sr; s_rdata = vecs[k].srd;
      #2;
      check($sformatf("vec%0d_s_valid", k), rr_s_valid, vecs[k].e_sv);
      check($sformatf("vec%0d_s_addr", k), rr_s_addr, vecs[k].e_saddr);
      check($sformatf("vec%0d_s_wdata", k), rr_s_wdata, vecs[k].e_swdata);
      check($sformatf("vec%0d_s_wstrb", k), rr_s_wstrb, vecs[k].e_swstrb);
      check($sformatf("vec%0d_m0_ready", k), rr_m0_ready, vecs[k].e_r0);
      check($sformatf("vec%0d_m1_ready", k), rr_m1_ready, vecs[k].e_r1);
      check($sformatf("vec%0d_m0_rdata", k), rr_m0_rdata, vecs[k].e_rd0);
      check($sformatf("vec%0d_m1_rdata", k), rr_m1_rdata, vecs[k].e_rd1);
      check($sformatf("vec%0d_irq", k), rr_irq, 0);
      next_cycle();
    end

    // ---- timeout: m1 write to unmapped address, slave silent ----
    do_reset();
    m1_valid = 1; m1_addr = 32'h9000_0000; m1_wdata = 32'h1; m1_wstrb = 4'hF;
    irq_seen = 0;
    for (int c = 0; c <= T; c++) begin
      #2;
      if (rr_irq) irq_seen++;
      check($sformatf("tmo_c%0d_s_valid", c), rr_s_valid, (c >= 1) ? 1 : 0);
      check($sformatf("tmo_c%0d_m1_ready", c), rr_m1_ready, (c == T) ? 1 : 0);
      if (c == T) check("tmo_m1_rdata", rr_m1_rdata, ERR_VAL);
      next_cycle();
    end
    m1_valid = 0;
    #2;
    if (rr_irq) irq_seen++;
    check("tmo_irq_pulses", irq_seen, 1);
    check("tmo_err_addr", rr_err_addr, 32'h9000_0000);
    check("tmo_err_master", rr_err_master, 1);
    check("tmo_back_idle", rr_state, 0);
    next_cycle();

    // ---- ready arrives in the watchdog cycle: real data, no irq ----
    m0_valid = 1; m0_addr = 32'h0000_0044; m0_wstrb = 4'h0;
    for (int c = 0; c <= T; c++) begin
      if (c == T) begin s_ready = 1; s_rdata = 32'hCAFE_0001; end
      #2;
      check($sformatf("sim_c%0d_irq", c), rr_irq, 0);
      check($sformatf("sim_c%0d_m0_ready", c), rr_m0_ready, (c == T) ? 1 : 0);
      if (c == T) check("sim_m0_rdata", rr_m0_rdata, 32'hCAFE_0001);
      next_cycle();
    end
    m0_valid = 0; s_ready = 0;
    #2;
    check("sim_err_addr_kept", rr_err_addr, 32'h9000_0000);
    check("sim_err_master_kept", rr_err_master, 1);
    next_cycle();

    // ---- abort: m1 drops valid mid-BUSY; fairness must not move ----
    m1_valid = 1; m1_addr = 32'h0000_0080;
    for (int c = 0; c < 3; c++) begin
      #2;
      check($sformatf("abort_c%0d_s_valid", c), rr_s_valid, (c >= 1) ? 1 : 0);
      next_cycle();
    end
    m1_valid = 0;
    #2;
    check("abort_s_valid", rr_s_valid, 0);
    check("abort_m1_ready", rr_m1_ready, 0);
    check("abort_irq", rr_irq, 0);
    next_cycle();
    #2;
    check("abort_idle", rr_state, 0);
    next_cycle();
    // last completion was m0, so contention now goes to m1
    m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'h0000_0A0A;
    next_cycle();
    #2;
    check("abort_next_m1_ready", rr_m1_ready, 1);
    check("abort_next_m0_ready", rr_m0_ready, 0);
    next_cycle();
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    next_cycle();

    // ---- reset while BUSY ----
    m0_valid = 1; m0_addr = 32'h0000_0010; s_ready = 1; s_rdata = 32'h1;
    repeat (2) next_cycle();            // m0 completes: last grant is now 0
    m0_valid = 0; s_ready = 0;
    next_cycle();
    m1_valid = 1; m1_addr = 32'h0000_0020;
    next_cycle();
    #2;
    check("rst_busy_s_valid", rr_s_valid, 1);
    next_cycle();
    #1 reset = 1'b1;
    #1;
    check("rst_mid_s_valid", rr_s_valid, 0);
    check("rst_mid_s_addr", rr_s_addr, 0);
    check("rst_mid_m1_ready", rr_m1_ready, 0);
    check("rst_mid_irq", rr_irq, 0);
    check("rst_mid_err_addr", rr_err_addr, 0);
    check("rst_mid_err_master", rr_err_master, 0);
    next_cycle();
    reset = 1'b0;
    m0_valid = 1; s_ready = 1; s_rdata = 32'h0000_0B0B;
    next_cycle();
    #2;
    check("rst_after_m0_ready", rr_m0_ready, 1);
    check("rst_after_m1_ready", rr_m1_ready, 0);
    next_cycle();

    // ---- fixed priority: m0 always wins until it drops valid ----
    do_reset();
    m0_valid = 1; m1_valid = 1; m0_addr = 32'h100; m1_addr = 32'h200;
    s_ready = 1; s_rdata = 32'h0000_F00D;
    for (int c = 0; c < 6; c++) begin
      #2;
      check($sformatf("fp_c%0d_m0_ready", c), fp_m0_ready, (c % 2 == 1) ? 1 : 0);
      check($sformatf("fp_c%0d_m1_ready", c), fp_m1_ready, 0);
      next_cycle();
    end
    m0_valid = 0;
    #2;
    check("fp_drop_m1_ready", fp_m1_ready, 0);
    next_cycle();
    #2;
    check("fp_m1_served", fp_m1_ready, 1);
    check("fp_m1_rdata", fp_m1_rdata, 32'h0000_F00D);
    next_cycle();

    // ---- randomized run against the reference model ----
    do_reset();
    for (int i = 0; i < 2; i++) begin mv[i] = 0; ma[i] = '0; mw[i] = '0; ms[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mv[i] || e_ready[i]) begin
          // after a completion a master may immediately issue a new request
          mv[i] = ($urandom_range(0, 2) == 0) || (mv[i] && $urandom_range(0, 1) == 1);
          ma[i] = $urandom & 32'hFFFF_FFFC;
          mw[i] = $urandom;
          ms[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        end else if ($urandom_range(0, 63) == 0) begin
          mv[i] = 0;   // occasional protocol violation
        end
      end
      m0_valid = mv[0]; m0_addr = ma[0]; m0_wdata = mw[0]; m0_wstrb = ms[0];
      m1_valid = mv[1]; m1_addr = ma[1]; m1_wdata = mw[1]; m1_wstrb = ms[1];
      s_ready = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
      #2;
      model_step();
      for (int i = 0; i < 2; i++) if (e_ready[i]) exp_q.push_back({i[0], e_rdata[i]});
      check("rnd_s_valid", rr_s_valid, e_sv);
      check("rnd_s_addr", rr_s_addr, e_saddr);
      check("rnd_s_wdata", rr_s_wdata, e_swdata);
      check("rnd_s_wstrb", rr_s_wstrb, e_swstrb);
      check("rnd_m0_ready", rr_m0_ready, e_ready[0]);
      check("rnd_m1_ready", rr_m1_ready, e_ready[1]);
      check("rnd_m0_rdata", rr_m0_rdata, e_rdata[0]);
      check("rnd_m1_rdata", rr_m1_rdata, e_rdata[1]);
      check("rnd_irq", rr_irq, e_irq);
      check("rnd_err_addr", rr_err_addr, e_err_addr);
      check("rnd_err_master", rr_err_master, e_err_master);
      if (rr_m0_ready || rr_m1_ready) begin
        got  = rr_m1_ready ? {1'b1, rr_m1_rdata} : {1'b0, rr_m0_rdata};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
        check("sb_master", 32'(got[32]), 32'(want[32]));
        check("sb_rdata", got[31:0], want[31:0]);
      end
      next_cycle();
    end
    check("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
